// File: rtl/fdiv_mul.sv
`timescale 1ns/1ps
// fdiv_mul: divider completion stage; aligns the dividend with the
// returning reciprocal and forms z = x * (1/y) with truncation.
module fdiv_mul #(
  parameter int FINV_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] recip_x,
  input  logic [31:0] recip_y,
  output logic        out_valid,
  output logic [31:0] z
);

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    logic        xz;
    logic        xi;
    logic        yz;
    logic        yi;
  } dl_t;

  dl_t                din;
  dl_t                dl_q [FINV_LAT];
  logic [FINV_LAT-1:0] dlv_q;
  logic [FINV_LAT-1:0] dlv_d;
  dl_t                al;
  logic               alv;

  logic               m1v_q;
  logic               m1_s_d, m1_s_q;
  logic signed [9:0]  m1_e_d, m1_e_q;
  logic [47:0]        m1_p_d, m1_p_q;
  logic [3:0]         m1_f_d, m1_f_q;

  logic               m2v_q;
  logic               m2_s_q;
  logic signed [9:0]  m2_e_d, m2_e_q;
  logic [22:0]        m2_m_d, m2_m_q;
  logic [3:0]         m2_f_q;

  logic               ov_q;
  logic [31:0]        z_d, z_q;

  assign recip_x = y;

  always_comb begin
    din.s  = x[31];
    din.e  = x[30:23];
    din.m  = x[22:0];
    din.xz = (x[30:23] == 8'h00);
    din.xi = (x[30:23] == 8'hFF);
    din.yz = (y[30:23] == 8'h00);
    din.yi = (y[30:23] == 8'hFF);
  end

  always_comb begin
    dlv_d    = '0;
    dlv_d[0] = in_valid;
    for (int i = 1; i < FINV_LAT; i++) begin
      dlv_d[i] = dlv_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    dl_q[0] <= din;
    for (int i = 1; i < FINV_LAT; i++) begin
      dl_q[i] <= dl_q[i-1];
    end
  end

  assign al  = dl_q[FINV_LAT-1];
  assign alv = dlv_q[FINV_LAT-1];

  // M1: sign, biased exponent sum and full 24x24 product
  always_comb begin
    m1_s_d = al.s ^ recip_y[31];
    m1_e_d = $signed({2'b00, al.e})
           + $signed({2'b00, recip_y[30:23]})
           - 10'sd127;
    m1_p_d = {24'd0, 1'b1, al.m}
           * {24'd0, 1'b1, recip_y[22:0]};
    m1_f_d = {al.xi, al.yz, al.xz, al.yi};
  end

  always_comb begin
    if (m1_p_q[47]) begin
      m2_m_d = m1_p_q[46:24];
      m2_e_d = m1_e_q + 10'sd1;
    end else begin
      m2_m_d = m1_p_q[45:23];
      m2_e_d = m1_e_q;
    end
  end

  always_ff @(posedge clk) begin
    m1_s_q <= m1_s_d;
    m1_e_q <= m1_e_d;
    m1_p_q <= m1_p_d;
    m1_f_q <= m1_f_d;
    m2_s_q <= m1_s_q;
    m2_e_q <= m2_e_d;
    m2_m_q <= m2_m_d;
    m2_f_q <= m1_f_q;
  end

  // infinity class wins over zero class, then range limits
  always_comb begin
    z_d = z_q;
    if (m2v_q) begin
      if (m2_f_q[3] | m2_f_q[2]) begin
        z_d = {m2_s_q, 8'hFF, 23'd0};
      end else if (m2_f_q[1] | m2_f_q[0]) begin
        z_d = {m2_s_q, 31'd0};
      end else if (m2_e_q >= 10'sd255) begin
        z_d = {m2_s_q, 8'hFF, 23'd0};
      end else if (m2_e_q <= 10'sd0) begin
        z_d = {m2_s_q, 31'd0};
      end else begin
        z_d = {m2_s_q, m2_e_q[7:0], m2_m_q};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dlv_q <= '0;
      m1v_q <= 1'b0;
      m2v_q <= 1'b0;
      ov_q  <= 1'b0;
      z_q   <= '0;
    end else begin
      dlv_q <= dlv_d;
      m1v_q <= alv;
      m2v_q <= m1v_q;
      ov_q  <= m2v_q;
      z_q   <= z_d;
    end
  end

  assign out_valid = ov_q;
  assign z         = z_q;

endmodule

// File: tb/tb_fdiv_mul.sv
`timescale 1ns/1ps
// tb_fdiv_mul: scoreboard bench with a 3-cycle reciprocal model.
module tb_fdiv_mul;

  typedef struct {
    logic [31:0] z;
    int          cyc;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tvalid = 1'b0;
  logic [31:0] tx = '0;
  logic [31:0] ty = '0;
  logic [31:0] rx;
  logic [31:0] ry;
  logic        ov;
  logic [31:0] zo;
  logic [31:0] rp [3];
  int          cyc = 0;
  int          checks = 0;
  int          passes = 0;

  res_t        exp_q [$];
  res_t        got_q [$];
  logic [31:0] op_x [$];
  logic [31:0] op_y [$];
  logic [31:0] op_e [$];
  bit          op_v [$];

  fdiv_mul #(.FINV_LAT(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (tvalid),
    .x        (tx),
    .y        (ty),
    .recip_x  (rx),
    .recip_y  (ry),
    .out_valid(ov),
    .z        (zo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] recip_fn(logic [31:0] v);
    case (v)
      32'h40400000: return 32'h3EAAAAAA;
      32'h00000000: return 32'h7F800000;
      32'h3F000000: return 32'h40000000;
      32'h40800000: return 32'h3E800000;
      default: begin
        if (v[22:0] == 23'd0)
          return {v[31], 8'd254 - v[30:23], 23'd0};
        return {v[31], 8'd253 - v[30:23], ~v[22:0]};
      end
    endcase
  endfunction

  always @(posedge clk) begin
    rp[0] <= rx;
    rp[1] <= rp[0];
    rp[2] <= rp[1];
  end

  assign ry = recip_fn(rp[2]);

  function automatic logic [31:0] ref_z(logic [31:0] a, logic [31:0] b);
    logic [31:0] r;
    logic        s;
    logic [47:0] p;
    logic [22:0] m;
    int          e;
    r = recip_fn(b);
    s = a[31] ^ r[31];
    if (a[30:23] == 8'hFF || b[30:23] == 8'h00) return {s, 8'hFF, 23'd0};
    if (a[30:23] == 8'h00 || b[30:23] == 8'hFF) return {s, 31'd0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, r[22:0]});
    e = int'(a[30:23]) + int'(r[30:23]) - 127;
    if (p[47]) begin
      e = e + 1;
      m = p[46:24];
    end else begin
      m = p[45:23];
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, e[7:0], m};
  endfunction

  function automatic logic [31:0] rnd_norm();
    logic [31:0] v;
    v[31]    = 1'($urandom_range(0, 1));
    v[30:23] = 8'($urandom_range(100, 150));
    v[22:0]  = 23'($urandom);
    return v;
  endfunction

  task automatic clear_ops();
    op_x.delete();
    op_y.delete();
    op_e.delete();
    op_v.delete();
  endtask

  task automatic add_op(bit v, logic [31:0] a, logic [31:0] b, logic [31:0] e);
    op_v.push_back(v);
    op_x.push_back(a);
    op_y.push_back(b);
    op_e.push_back(e);
  endtask

  // drives queued ops one per cycle and records every result seen
  task automatic run_ops();
    exp_q.delete();
    got_q.delete();
    for (int i = 0; i < op_x.size(); i++) begin
      @(negedge clk);
      if (ov) got_q.push_back('{zo, cyc});
      tvalid = op_v[i];
      tx     = op_x[i];
      ty     = op_y[i];
      if (op_v[i]) exp_q.push_back('{op_e[i], cyc + 6});
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (ov) got_q.push_back('{zo, cyc});
      tvalid = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ov !== 1'b0) $display("FAIL reset out_valid got %b want 0", ov);
    else passes++;
    checks++;
    if (zo !== 32'h0) $display("FAIL reset z got %h want 00000000", zo);
    else passes++;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    @(negedge clk);
    ty = 32'h40000000;
    #1;
    checks++;
    if (rx !== 32'h40000000) $display("FAIL recip_x got %h want 40000000", rx);
    else passes++;
    clear_ops();
    add_op(1, 32'h40C00000, 32'h40000000, 32'h40400000);
    add_op(1, 32'h3F800000, 32'h40400000, 32'h3EAAAAAA);
    add_op(1, 32'hBF800000, 32'h40400000, 32'hBEAAAAAA);
    add_op(1, 32'h3F800000, 32'h00000000, 32'h7F800000);
    add_op(1, 32'h80000000, 32'h40000000, 32'h80000000);
    add_op(1, 32'h7F800000, 32'hC0000000, 32'hFF800000);
    add_op(1, 32'h7F000000, 32'h3F000000, 32'h7F800000);
    add_op(1, 32'h00800000, 32'h40800000, 32'h00000000);
    run_ops();
    checks++;
    if (got_q.size() != exp_q.size())
      $display("FAIL directed count got %0d want %0d", got_q.size(), exp_q.size());
    else passes++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].z !== exp_q[i].z)
        $display("FAIL directed[%0d] z got %h want %h", i, got_q[i].z, exp_q[i].z);
      else passes++;
      checks++;
      if (got_q[i].cyc != exp_q[i].cyc)
        $display("FAIL directed[%0d] cycle got %0d want %0d", i, got_q[i].cyc, exp_q[i].cyc);
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] b;
    clear_ops();
    for (int i = 0; i < 21; i++) begin
      a = rnd_norm();
      b = rnd_norm();
      if (i == 7) add_op(0, a, b, 32'h0);
      else add_op(1, a, b, ref_z(a, b));
    end
    run_ops();
    checks++;
    if (got_q.size() != 20)
      $display("FAIL stream count got %0d want 20", got_q.size());
    else passes++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].z !== exp_q[i].z)
        $display("FAIL stream[%0d] z got %h want %h", i, got_q[i].z, exp_q[i].z);
      else passes++;
      checks++;
      if (got_q[i].cyc != exp_q[i].cyc)
        $display("FAIL stream[%0d] cycle got %0d want %0d", i, got_q[i].cyc, exp_q[i].cyc);
      else passes++;
    end
  endtask

  task automatic test_reset_midflight();
    int seen;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tvalid = 1'b1;
      tx     = 32'h40C00000 + 32'(i);
      ty     = 32'h40000000;
    end
    @(negedge clk);
    tvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (ov !== 1'b0) $display("FAIL midrst out_valid got %b want 0", ov);
    else passes++;
    checks++;
    if (zo !== 32'h0) $display("FAIL midrst z got %h want 00000000", zo);
    else passes++;
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ov) seen++;
    end
    checks++;
    if (seen != 0) $display("FAIL midrst stale results got %0d want 0", seen);
    else passes++;
    clear_ops();
    add_op(1, 32'h40C00000, 32'h40000000, 32'h40400000);
    run_ops();
    checks++;
    if (got_q.size() != 1)
      $display("FAIL postrst count got %0d want 1", got_q.size());
    else passes++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].z !== exp_q[i].z)
        $display("FAIL postrst z got %h want %h", got_q[i].z, exp_q[i].z);
      else passes++;
      checks++;
      if (got_q[i].cyc != exp_q[i].cyc)
        $display("FAIL postrst cycle got %0d want %0d", got_q[i].cyc, exp_q[i].cyc);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
